divider_seq_32bit: RTL and testbench

DIVIDER_SEQ_32BIT -- requirements
Module: divider_seq_32bit

---
 rtl/divider_seq_32bit.sv | 126 ++++++++++++
 tb/tb_divider_seq_32bit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/divider_seq_32bit.sv
// divider_seq_32bit
// Sequential radix-2 restoring divider covering DIVU / DIV / REMU / REM.
// Operands are reduced to magnitudes on acceptance, divided unsigned, and
// the signs are re-applied in a single fix-up cycle. Latency is fixed.
//
// Ports:
//   CLK          clock, all state on rising edge
//   RST          synchronous active-high reset
//   START        request, sampled only while BUSY=0 (IDLE or FIN)
//   OP[1:0]      00 DIVU, 01 DIV, 10 REMU, 11 REM
//   A, B         dividend, divisor
//   BUSY         high in CALC and FIX
//   DONE         one-cycle pulse, OUT valid
//   OUT          quotient or remainder, held until the next FIX
//   DIV_BY_ZERO  B==0 flag of the last completed operation
module divider_seq_32bit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [1:0]            OP,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] OUT,
    output logic                  DIV_BY_ZERO
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] STEPS = CW'(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic [W-1:0]  dvd;     // dividend magnitude, shifts out MSB-first, quotient shifts in at LSB
    logic [W-1:0]  dsr;     // divisor magnitude
    logic [W-1:0]  rem;     // partial remainder
    logic          neg_q;   // operand signs differ (signed ops only)
    logic          neg_r;   // dividend negative (signed ops only)
    logic          bzero;
    logic [W-1:0]  out_q;
    logic          dbz_q;

    logic          sa, sb;
    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic [W-1:0]  q_fix, r_fix;

    assign sa = OP[0] & A[W-1];
    assign sb = OP[0] & B[W-1];

    // 33-bit trial subtraction: bit W set means the divisor did not fit.
    // Working on magnitudes keeps 0x80000000 representable as unsigned.
    assign shifted = {rem, dvd[W-1]};
    assign trial   = shifted - {1'b0, dsr};

    // A zero divisor yields an all-ones quotient that must not be negated;
    // the remainder is then |A| and the sign fix restores A exactly.
    assign q_fix = (neg_q && !bzero) ? -dvd : dvd;
    assign r_fix = neg_r ? -rem : rem;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            bzero <= 1'b0;
            out_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    // FIN accepts START too, giving back-to-back issue.
                    if (START) begin
                        op_q  <= OP;
                        dvd   <= sa ? -A : A;
                        dsr   <= sb ? -B : B;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        bzero <= (B == '0);
                        state <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    // Steps run at cnt 0..W-1; the cycle at cnt==W only
                    // advances, which pins DONE at E0+34 for W=32.
                    if (cnt == STEPS) begin
                        state <= S_FIX;
                    end else begin
                        rem <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
                        dvd <= {dvd[W-2:0], ~trial[W]};
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    out_q <= op_q[1] ? r_fix : q_fix;
                    dbz_q <= bzero;
                    state <= S_FIN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY        = (state == S_CALC) || (state == S_FIX);
    assign DONE        = (state == S_FIN);
    assign OUT         = out_q;
    assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_divider_seq_32bit.sv
// tb_divider_seq_32bit
// Directed bench for divider_seq_32bit: expected {DIV_BY_ZERO, OUT} pushed
// to a scoreboard when an operation is issued, popped on DONE. Inputs are
// driven and outputs sampled on the falling edge.
module tb_divider_seq_32bit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, dbz;
    logic [W-1:0] out;

    int tests = 0;
    int fails = 0;
    logic [W:0] sb_q[$];

    always #5 clk = ~clk;

    divider_seq_32bit #(.DATA_WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .START(start), .OP(op), .A(a), .B(b),
        .BUSY(busy), .DONE(done), .OUT(out), .DIV_BY_ZERO(dbz)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model on 64-bit signed arithmetic; truncation to 32 bits
    // gives the 0x80000000 overflow quotient naturally.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy;
        logic [W-1:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (y == 0)         r = o[1] ? x : {W{1'b1}};
        else if (!o[0])     r = o[1] ? (x % y) : (x / y);
        else                r = o[1] ? W'(sx % sy) : W'(sx / sy);
        return {(y == 0), r};
    endfunction

    // Drives START for the edge following the current falling edge; returns
    // on the next falling edge (cycle index 0 after acceptance).
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        sb_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_result(input string tag);
        logic [W:0] e;
        if (sb_q.size() == 0) e = '1;
        else e = sb_q.pop_front();
        chk({tag, ".out"}, out, e[W-1:0]);
        chk({tag, ".dbz"}, dbz, e[W]);
        chk({tag, ".busy_fin"}, busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int k;
        start_op(o, x, y);
        wait_done(k);
        chk({tag, ".lat"}, k, 34);
        check_result(tag);
        @(negedge clk);
    endtask

    initial begin
        int k;
        logic [W-1:0] hold_out;
        logic seen;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.out", out, 0);
        chk("rst.dbz", dbz, 1'b0);

        // First START on the first edge with RST low.
        rst = 1'b0;
        run_op("divu_100_7", 2'b00, 100, 7);
        run_op("remu_100_7", 2'b10, 100, 7);
        run_op("div_m7_2",   2'b01, 32'hFFFF_FFF9, 2);
        run_op("rem_m7_2",   2'b11, 32'hFFFF_FFF9, 2);
        run_op("div_5_0",    2'b01, 5, 0);
        run_op("remu_5_0",   2'b10, 5, 0);
        run_op("rem_m7_0",   2'b11, 32'hFFFF_FFF9, 0);
        run_op("div_m7_0",   2'b01, 32'hFFFF_FFF9, 0);
        run_op("div_ovf",    2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_big",   2'b00, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("div_min_3",  2'b01, 32'h8000_0000, 3);
        for (int i = 0; i < 6; i++)
            run_op("rand", 2'(i), $urandom, $urandom_range(1, 1000));

        // START mid-CALC ignored; START in FIN accepted back-to-back.
        start_op(2'b00, 100, 7);
        repeat (10) @(negedge clk);
        op = 2'b10; a = 1000; b = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk("ign.lat", k, 23);
        check_result("ign");
        hold_out = out;
        start_op(2'b11, 32'hFFFF_FF9C, 7);
        chk("hold.out", out, hold_out);
        wait_done(k);
        chk("b2b.lat", k, 34);
        check_result("b2b");

        // No DONE follows: the ignored START must not have been queued.
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("noqueue.done", seen, 1'b0);

        // Reset at CALC step 20, with START also high during reset.
        start_op(2'b01, 12345, 67);
        repeat (20) @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 2'b00; a = 9; b = 3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        void'(sb_q.pop_back());
        chk("abort.busy", busy, 1'b0);
        chk("abort.out", out, 0);
        chk("abort.dbz", dbz, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort.nodone", seen, 1'b0);

        run_op("post_rst", 2'b00, 100, 7);
        chk("sb.empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
